// File: rtl/calc_alu_sequencer.sv
// Sequencer for the external 8-bit sign-magnitude add/subtract ALU: registers a
// request onto the ALU inputs, waits a settle time, captures and presents the result.
module calc_alu_sequencer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic              req_sign_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_sign_b,
  input  logic              req_sub,
  input  logic              req_acc,
  input  logic              clear,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_add_sub,
  output logic              alu_sign_a,
  output logic              alu_sign_b,
  input  logic [DATA_W:0]   alu_magnitude,
  input  logic              alu_final_sign,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_mag,
  output logic              res_sign,
  output logic              res_ovf,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic                alu_add_sub_q, alu_add_sub_d;
  logic                alu_sign_a_q, alu_sign_a_d, alu_sign_b_q, alu_sign_b_d;
  logic [DATA_W-1:0]   res_mag_q, res_mag_d;
  logic                res_sign_q, res_sign_d, res_ovf_q, res_ovf_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   acc_mag_q, acc_mag_d;
  logic                acc_sign_q, acc_sign_d;
  logic                err_q, err_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   cap_mag;
  logic                cap_ovf, cap_sign;

  // Captured ALU result with negative zero folded to +0
  assign cap_mag  = alu_magnitude[DATA_W-1:0];
  assign cap_ovf  = alu_magnitude[DATA_W];
  assign cap_sign = alu_final_sign & (cap_mag != '0);

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_add_sub_d = alu_add_sub_q;
    alu_sign_a_d  = alu_sign_a_q;
    alu_sign_b_d  = alu_sign_b_q;
    res_mag_d     = res_mag_q;
    res_sign_d    = res_sign_q;
    res_ovf_d     = res_ovf_q;
    res_valid_d   = res_valid_q;
    acc_mag_d     = acc_mag_q;
    acc_sign_d    = acc_sign_q;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          acc_mag_d   = '0;
          acc_sign_d  = 1'b0;
          err_d       = 1'b0;
          res_valid_d = 1'b0;
        end else if (req_valid && req_ready_q) begin
          alu_a_d       = req_acc ? acc_mag_q : req_a;
          alu_sign_a_d  = req_acc ? acc_sign_q : req_sign_a;
          alu_b_d       = req_b;
          alu_sign_b_d  = req_sign_b;
          alu_add_sub_d = req_sub;
          state_d       = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (clear) begin
          acc_mag_d  = '0;
          acc_sign_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end else if (SETTLE_CYCLES > 1) begin
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = S_SETTLE;
        end else begin
          state_d = S_CAPTURE;
        end
      end

      S_SETTLE: begin
        if (clear) begin
          acc_mag_d  = '0;
          acc_sign_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        if (clear) begin
          acc_mag_d  = '0;
          acc_sign_d = 1'b0;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          res_mag_d  = cap_mag;
          res_sign_d = cap_sign;
          res_ovf_d  = cap_ovf;
          acc_mag_d  = cap_mag;
          acc_sign_d = cap_sign;
          err_d      = err_q | cap_ovf;
          state_d    = S_HOLD;
        end
      end

      S_HOLD: begin
        // Valid rises one cycle after the result registers load, so res_* are settled first
        if (clear) begin
          acc_mag_d   = '0;
          acc_sign_d  = 1'b0;
          err_d       = 1'b0;
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (!res_valid_q) begin
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == S_IDLE) && !err_d;
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_add_sub_q <= 1'b0;
      alu_sign_a_q  <= 1'b0;
      alu_sign_b_q  <= 1'b0;
      res_mag_q     <= '0;
      res_sign_q    <= 1'b0;
      res_ovf_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      acc_mag_q     <= '0;
      acc_sign_q    <= 1'b0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_add_sub_q <= alu_add_sub_d;
      alu_sign_a_q  <= alu_sign_a_d;
      alu_sign_b_q  <= alu_sign_b_d;
      res_mag_q     <= res_mag_d;
      res_sign_q    <= res_sign_d;
      res_ovf_q     <= res_ovf_d;
      res_valid_q   <= res_valid_d;
      acc_mag_q     <= acc_mag_d;
      acc_sign_q    <= acc_sign_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign res_valid   = res_valid_q;
  assign res_mag     = res_mag_q;
  assign res_sign    = res_sign_q;
  assign res_ovf     = res_ovf_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_add_sub = alu_add_sub_q;
  assign alu_sign_a  = alu_sign_a_q;
  assign alu_sign_b  = alu_sign_b_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed bench for calc_alu_sequencer: a default-settle instance and a
// SETTLE_CYCLES=4 instance, each driven by a behavioural sign-magnitude ALU.
module tb_calc_alu_sequencer;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] req_a, req_b;
  logic req_sign_a, req_sign_b, req_sub, req_acc;
  logic req_valid, req_valid4, clear, clear4, res_ready;

  logic req_ready, busy, err, res_valid, res_sign, res_ovf;
  logic [DW-1:0] res_mag, alu_a, alu_b;
  logic alu_add_sub, alu_sign_a, alu_sign_b;
  logic [DW:0] alu_magnitude;
  logic alu_final_sign;

  logic req_ready4, busy4, err4, res_valid4, res_sign4, res_ovf4;
  logic [DW-1:0] res_mag4, alu_a4, alu_b4;
  logic alu_add_sub4, alu_sign_a4, alu_sign_b4;
  logic [DW:0] alu_magnitude4;
  logic alu_final_sign4;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  // Sign-magnitude add/subtract ALU: {final_sign, carry, magnitude}
  function automatic logic [DW+1:0] alu_f(input logic [DW-1:0] a, input logic sa,
                                          input logic [DW-1:0] b, input logic sb,
                                          input logic sub);
    logic sbe;
    logic [DW:0] m;
    logic s;
    sbe = sb ^ sub;
    if (sa == sbe) begin
      m = {1'b0, a} + {1'b0, b};
      s = sa;
    end else if (a >= b) begin
      m = {1'b0, a - b};
      s = sa;
    end else begin
      m = {1'b0, b - a};
      s = sbe;
    end
    return {s, m};
  endfunction

  assign {alu_final_sign, alu_magnitude} = alu_f(alu_a, alu_sign_a, alu_b, alu_sign_b, alu_add_sub);
  assign {alu_final_sign4, alu_magnitude4} = alu_f(alu_a4, alu_sign_a4, alu_b4, alu_sign_b4, alu_add_sub4);

  calc_alu_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_sign_a(req_sign_a), .req_b(req_b), .req_sign_b(req_sign_b),
    .req_sub(req_sub), .req_acc(req_acc), .clear(clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_add_sub(alu_add_sub),
    .alu_sign_a(alu_sign_a), .alu_sign_b(alu_sign_b),
    .alu_magnitude(alu_magnitude), .alu_final_sign(alu_final_sign),
    .res_valid(res_valid), .res_ready(res_ready), .res_mag(res_mag),
    .res_sign(res_sign), .res_ovf(res_ovf), .busy(busy), .err(err));

  calc_alu_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a), .req_sign_a(req_sign_a), .req_b(req_b), .req_sign_b(req_sign_b),
    .req_sub(req_sub), .req_acc(req_acc), .clear(clear4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_add_sub(alu_add_sub4),
    .alu_sign_a(alu_sign_a4), .alu_sign_b(alu_sign_b4),
    .alu_magnitude(alu_magnitude4), .alu_final_sign(alu_final_sign4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_mag(res_mag4),
    .res_sign(res_sign4), .res_ovf(res_ovf4), .busy(busy4), .err(err4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until the accepting edge
  task automatic do_req(input bit sel4, input logic [DW-1:0] a, input logic sa,
                        input logic [DW-1:0] b, input logic sb,
                        input logic sub, input logic acc);
    int n;
    n = 0;
    while (!(sel4 ? req_ready4 : req_ready) && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_before_req", 32'(sel4 ? req_ready4 : req_ready), 32'd1);
    req_a = a; req_sign_a = sa; req_b = b; req_sign_b = sb; req_sub = sub; req_acc = acc;
    if (sel4) req_valid4 = 1'b1;
    else      req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
    req_valid4 = 1'b0;
  endtask

  task automatic wait_valid(input bit sel4, output int cycles);
    cycles = 0;
    while (!(sel4 ? res_valid4 : res_valid) && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_valid4 = 0; clear = 0; clear4 = 0; res_ready = 0;
    req_a = '0; req_b = '0; req_sign_a = 0; req_sign_b = 0; req_sub = 0; req_acc = 0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_mag", 32'(res_mag), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // +25 + +17
    do_req(0, 8'd25, 0, 8'd17, 0, 0, 0);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_alu_a", 32'(alu_a), 32'd25);
    chk("add_alu_b", 32'(alu_b), 32'd17);
    wait_valid(0, lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_mag", 32'(res_mag), 32'd42);
    chk("add_sign", 32'(res_sign), 32'd0);
    chk("add_ovf", 32'(res_ovf), 32'd0);
    take();
    chk("add_valid_drop", 32'(res_valid), 32'd0);
    chk("add_idle_ready", 32'(req_ready), 32'd1);

    // +10 - +30, then accumulate + +5
    do_req(0, 8'd10, 0, 8'd30, 0, 1, 0);
    wait_valid(0, lat);
    chk("sub_mag", 32'(res_mag), 32'd20);
    chk("sub_sign", 32'(res_sign), 32'd1);
    take();
    do_req(0, 8'd99, 0, 8'd5, 0, 0, 1);
    chk("acc_alu_a", 32'(alu_a), 32'd20);
    chk("acc_alu_sign_a", 32'(alu_sign_a), 32'd1);
    wait_valid(0, lat);
    chk("acc_mag", 32'(res_mag), 32'd15);
    chk("acc_sign", 32'(res_sign), 32'd1);
    take();

    // Overflow, refused request, clear racing a request
    do_req(0, 8'd200, 0, 8'd100, 0, 0, 0);
    wait_valid(0, lat);
    chk("ovf_mag", 32'(res_mag), 32'd44);
    chk("ovf_flag", 32'(res_ovf), 32'd1);
    chk("ovf_err", 32'(err), 32'd1);
    take();
    req_a = 8'd1; req_b = 8'd1; req_acc = 0; req_sub = 0;
    req_valid = 1'b1;
    repeat (3) tick();
    chk("err_ready_low", 32'(req_ready), 32'd0);
    chk("err_not_busy", 32'(busy), 32'd0);
    chk("alu_b_held", 32'(alu_b), 32'd100);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 1'b0;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_ready", 32'(req_ready), 32'd1);
    chk("clr_priority_busy", 32'(busy), 32'd0);
    do_req(0, 8'd77, 1, 8'd3, 0, 0, 1);
    wait_valid(0, lat);
    chk("clr_acc_mag", 32'(res_mag), 32'd3);
    chk("clr_acc_sign", 32'(res_sign), 32'd0);
    take();

    // -7 - -7 gives +0
    do_req(0, 8'd7, 1, 8'd7, 1, 1, 0);
    wait_valid(0, lat);
    chk("zero_mag", 32'(res_mag), 32'd0);
    chk("zero_sign", 32'(res_sign), 32'd0);
    take();

    // Backpressure with a waiting request
    do_req(0, 8'd1, 0, 8'd2, 0, 0, 0);
    wait_valid(0, lat);
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_mag", 32'(res_mag), 32'd3);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 1'b0;
    take();
    chk("bp_valid_drop", 32'(res_valid), 32'd0);

    // Clear in HOLD discards the result and zeroes the accumulator
    do_req(0, 8'd5, 0, 8'd5, 0, 0, 0);
    wait_valid(0, lat);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("hold_clr_valid", 32'(res_valid), 32'd0);
    chk("hold_clr_busy", 32'(busy), 32'd0);
    do_req(0, 8'd0, 0, 8'd1, 0, 0, 1);
    wait_valid(0, lat);
    chk("hold_clr_acc", 32'(res_mag), 32'd1);
    take();

    // SETTLE_CYCLES=4: latency then abort in SETTLE
    do_req(1, 8'd100, 0, 8'd20, 0, 0, 0);
    wait_valid(1, lat);
    chk("s4_latency", 32'(lat), 32'd6);
    chk("s4_mag", 32'(res_mag4), 32'd120);
    take();
    do_req(1, 8'd50, 0, 8'd1, 0, 0, 0);
    tick();
    chk("s4_busy_settle", 32'(busy4), 32'd1);
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    chk("abort_busy", 32'(busy4), 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        if (res_valid4) seen++;
        tick();
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
    end
    do_req(1, 8'd0, 0, 8'd9, 0, 0, 1);
    wait_valid(1, lat);
    chk("abort_acc_mag", 32'(res_mag4), 32'd9);
    chk("abort_acc_sign", 32'(res_sign4), 32'd0);
    take();

    // Async reset during DRIVE
    do_req(0, 8'd40, 0, 8'd2, 0, 0, 0);
    chk("drive_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_alu_a", 32'(alu_a), 32'd0);
    chk("arst_alu_b", 32'(alu_b), 32'd0);
    chk("arst_res_mag", 32'(res_mag), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        if (res_valid) seen++;
        tick();
      end
      chk("arst_no_result", 32'(seen), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
